mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 15 +
 rtl/mem_stage_data_memory.sv | 31 +++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    // Access FSM: IDLE accepts requests, BUSY counts freeze cycles and completes.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int DEF_BASE_ADDR = 1024;  // byte address of data-memory word 0
    localparam int DEF_MEM_DEPTH = 64;    // number of 32-bit words
    localparam int DATA_W        = 32;    // data / address width
    localparam int REG_W         = 4;     // register-index width

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DEF_MEM_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Commit a write at the rising edge when enabled.
    // NOTE: the array has no reset branch on purpose; contents survive reset and a reset would force the array into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read port.
    always_comb begin
        rdata = mem[addr];
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: freezes the pipeline for WAIT_CYCLES per load/store,
// holds the request in latches, and completes it against data_memory.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_enable_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [DATA_W-1:0] ALU_res_in,
    input  logic [DATA_W-1:0] val_Rm_in,
    input  logic [REG_W-1:0]  Rd_in,
    output logic              wb_enable_out,
    output logic              mem_read_out,
    output logic [DATA_W-1:0] ALU_res_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [REG_W-1:0]  Rd_out,
    output logic              freeze,
    output logic              mem_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lat_wb_q, lat_wb_d;
    logic               lat_mr_q, lat_mr_d;
    logic               lat_mw_q, lat_mw_d;
    logic [DATA_W-1:0]  lat_alu_q, lat_alu_d;
    logic [DATA_W-1:0]  lat_val_q, lat_val_d;
    logic [REG_W-1:0]   lat_rd_q, lat_rd_d;

    logic               src_wb, src_mr, src_mw, src_rd_op;
    logic [DATA_W-1:0]  src_addr, src_val, byte_off, word_idx;
    logic               in_range, complete, mem_we;
    logic [DATA_W-1:0]  mem_rdata;

    // Select live inputs in IDLE or latched request in BUSY, and decode its address.
    always_comb begin
        src_wb    = (state_q == BUSY) ? lat_wb_q  : wb_enable_in;
        src_mr    = (state_q == BUSY) ? lat_mr_q  : mem_read_in;
        src_mw    = (state_q == BUSY) ? lat_mw_q  : mem_write_in;
        src_addr  = (state_q == BUSY) ? lat_alu_q : ALU_res_in;
        src_val   = (state_q == BUSY) ? lat_val_q : val_Rm_in;
        src_rd_op = src_mr & ~src_mw;  // a simultaneous write wins over the read
        byte_off  = src_addr - DATA_W'(BASE_ADDR);
        word_idx  = byte_off >> 2;
        in_range  = (src_addr >= DATA_W'(BASE_ADDR)) && (word_idx < DATA_W'(MEM_DEPTH));
    end

    // Next-state, latch loading and output muxing.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        lat_wb_d      = lat_wb_q;
        lat_mr_d      = lat_mr_q;
        lat_mw_d      = lat_mw_q;
        lat_alu_d     = lat_alu_q;
        lat_val_d     = lat_val_q;
        lat_rd_d      = lat_rd_q;
        complete      = 1'b0;
        mem_we        = 1'b0;
        freeze        = 1'b0;
        mem_err       = 1'b0;
        wb_enable_out = 1'b0;
        mem_read_out  = 1'b0;
        ALU_res_out   = '0;
        mem_data_out  = '0;
        Rd_out        = '0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    ALU_res_out = ALU_res_in;
                    Rd_out      = Rd_in;
                    if (!(mem_read_in || mem_write_in)) begin
                        wb_enable_out = wb_enable_in;
                    end else if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        freeze    = 1'b1;
                        lat_wb_d  = wb_enable_in;
                        lat_mr_d  = mem_read_in;
                        lat_mw_d  = mem_write_in;
                        lat_alu_d = ALU_res_in;
                        lat_val_d = val_Rm_in;
                        lat_rd_d  = Rd_in;
                        cnt_d     = CNT_W'(WAIT_CYCLES - 1);
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    ALU_res_out = lat_alu_q;
                    Rd_out      = lat_rd_q;
                    if (cnt_q != '0) begin
                        freeze = 1'b1;
                        cnt_d  = cnt_q - CNT_W'(1);
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (complete) begin
                wb_enable_out = src_wb;
                mem_read_out  = src_rd_op;
                mem_we        = src_mw & in_range;
                mem_data_out  = (src_rd_op && in_range) ? mem_rdata : '0;
                mem_err       = ~in_range;
            end
        end
    end

    // State, counter and request latches with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_wb_q  <= 1'b0;
            lat_mr_q  <= 1'b0;
            lat_mw_q  <= 1'b0;
            lat_alu_q <= '0;
            lat_val_q <= '0;
            lat_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_wb_q  <= lat_wb_d;
            lat_mr_q  <= lat_mr_d;
            lat_mw_q  <= lat_mw_d;
            lat_alu_q <= lat_alu_d;
            lat_val_q <= lat_val_d;
            lat_rd_q  <= lat_rd_d;
        end
    end

    data_memory #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_data_memory (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx[AW-1:0]),
        .wdata (src_val),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// traffic checked against an array-based model of the data memory.
module tb_mem_stage;

    localparam int WAIT  = 2;
    localparam int DEPTH = 64;
    localparam int BASE  = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // Inputs / outputs of the WAIT_CYCLES=2 instance
    logic        wb_in, mr_in, mw_in;
    logic [31:0] alu_in, val_in;
    logic [3:0]  rd_in;
    logic        wb_out, mr_out, freeze, mem_err;
    logic [31:0] alu_out, data_out;
    logic [3:0]  rd_out;
    // Inputs / outputs of the WAIT_CYCLES=0 instance
    logic        wb0_in, mr0_in, mw0_in;
    logic [31:0] alu0_in, val0_in;
    logic [3:0]  rd0_in;
    logic        wb0_out, mr0_out, freeze0, mem_err0;
    logic [31:0] alu0_out, data0_out;
    logic [3:0]  rd0_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model  [DEPTH];
    logic [31:0] model0 [DEPTH];
    bit          known0 [DEPTH];

    mem_stage #(.WAIT_CYCLES(WAIT), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .wb_enable_in(wb_in), .mem_read_in(mr_in), .mem_write_in(mw_in),
        .ALU_res_in(alu_in), .val_Rm_in(val_in), .Rd_in(rd_in),
        .wb_enable_out(wb_out), .mem_read_out(mr_out), .ALU_res_out(alu_out),
        .mem_data_out(data_out), .Rd_out(rd_out), .freeze(freeze), .mem_err(mem_err)
    );

    mem_stage #(.WAIT_CYCLES(0), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .rst(rst),
        .wb_enable_in(wb0_in), .mem_read_in(mr0_in), .mem_write_in(mw0_in),
        .ALU_res_in(alu0_in), .val_Rm_in(val0_in), .Rd_in(rd0_in),
        .wb_enable_out(wb0_out), .mem_read_out(mr0_out), .ALU_res_out(alu0_out),
        .mem_data_out(data0_out), .Rd_out(rd0_out), .freeze(freeze0), .mem_err(mem_err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= 32'(BASE)) && (((a - 32'(BASE)) >> 2) < 32'(DEPTH));
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - 32'(BASE)) >> 2);
    endfunction

    task automatic drive(input logic wb, mr, mw, input logic [31:0] a, d, input logic [3:0] r);
        wb_in = wb; mr_in = mr; mw_in = mw; alu_in = a; val_in = d; rd_in = r;
    endtask

    task automatic scramble();
        wb_in  = 1'($urandom); mr_in = 1'($urandom); mw_in = 1'($urandom);
        alu_in = $urandom; val_in = $urandom; rd_in = 4'($urandom);
    endtask

    // Non-memory op: same-cycle pass-through with no freeze.
    task automatic nonmem(input logic wb, input logic [31:0] a, input logic [3:0] r);
        drive(wb, 1'b0, 1'b0, a, $urandom, r);
        #2;
        check("nm_freeze", 32'(freeze), 32'(0));
        check("nm_wb", 32'(wb_out), 32'(wb));
        check("nm_alu", alu_out, a);
        check("nm_rd", 32'(rd_out), 32'(r));
        check("nm_mr", 32'(mr_out), 32'(0));
        check("nm_data", data_out, 32'(0));
        check("nm_err", 32'(mem_err), 32'(0));
        step();
    endtask

    // One memory access on the WAIT=2 instance, inputs scrambled while frozen.
    task automatic access(input logic wb, mr, mw, input logic [31:0] a, d, input logic [3:0] r);
        int          fz;
        logic        rd_op;
        logic [31:0] exp_data;
        drive(wb, mr, mw, a, d, r);
        #2;
        fz = 0;
        while (freeze === 1'b1 && fz < 10) begin
            fz++;
            check("bubble_wb", 32'(wb_out), 32'(0));
            check("bubble_mr", 32'(mr_out), 32'(0));
            check("bubble_err", 32'(mem_err), 32'(0));
            step();
            scramble();
            #2;
        end
        check("freeze_cycles", 32'(fz), 32'(WAIT));
        rd_op    = mr & ~mw;
        exp_data = (rd_op && in_rng(a)) ? model[idx_of(a)] : 32'(0);
        check("cpl_wb", 32'(wb_out), 32'(wb));
        check("cpl_mr", 32'(mr_out), 32'(rd_op));
        check("cpl_alu", alu_out, a);
        check("cpl_rd", 32'(rd_out), 32'(r));
        check("cpl_data", data_out, exp_data);
        check("cpl_err", 32'(mem_err), 32'(!in_rng(a)));
        if (mw && in_rng(a)) model[idx_of(a)] = d;
        step();
        drive(1'b0, 1'b0, 1'b0, 32'(0), 32'(0), 4'(0));
        #2;
        check("post_freeze", 32'(freeze), 32'(0));
        check("post_err", 32'(mem_err), 32'(0));
        step();
    endtask

    // One single-cycle access on the WAIT=0 instance.
    task automatic access0(input logic mr, mw, input logic [31:0] a, d);
        logic rd_op;
        logic [3:0] r;
        r = 4'($urandom);
        wb0_in = 1'b1; mr0_in = mr; mw0_in = mw; alu0_in = a; val0_in = d; rd0_in = r;
        rd_op = mr & ~mw;
        #2;
        check("w0_freeze", 32'(freeze0), 32'(0));
        check("w0_mr", 32'(mr0_out), 32'(rd_op));
        check("w0_wb", 32'(wb0_out), 32'(1));
        check("w0_alu", alu0_out, a);
        check("w0_rd", 32'(rd0_out), 32'(r));
        check("w0_err", 32'(mem_err0), 32'(!in_rng(a)));
        if (!in_rng(a) || !rd_op)
            check("w0_data", data0_out, 32'(0));
        else if (known0[idx_of(a)])
            check("w0_data", data0_out, model0[idx_of(a)]);
        if (mw && in_rng(a)) begin
            model0[idx_of(a)] = d;
            known0[idx_of(a)] = 1'b1;
        end
        step();
        mr0_in = 1'b0; mw0_in = 1'b0; wb0_in = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = int'($urandom_range(0, 7));
        if (k == 0) return 32'(BASE - 4 * int'($urandom_range(1, 8)) + int'($urandom_range(0, 3)));
        if (k == 1) return 32'(BASE + 4 * DEPTH + 4 * int'($urandom_range(0, 8)) + int'($urandom_range(0, 3)));
        return 32'(BASE + 4 * int'($urandom_range(0, DEPTH - 1)) + int'($urandom_range(0, 3)));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] a;
        int          op;

        for (int i = 0; i < DEPTH; i++) known0[i] = 1'b0;
        wb0_in = 1'b0; mr0_in = 1'b0; mw0_in = 1'b0; alu0_in = '0; val0_in = '0; rd0_in = '0;

        // Reset: all outputs forced low even with a request on the inputs.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'd1024, 32'h1, 4'd5);
        step();
        #2;
        check("rst_freeze", 32'(freeze), 32'(0));
        check("rst_err", 32'(mem_err), 32'(0));
        check("rst_wb", 32'(wb_out), 32'(0));
        check("rst_mr", 32'(mr_out), 32'(0));
        check("rst_alu", alu_out, 32'(0));
        check("rst_data", data_out, 32'(0));
        check("rst_rd", 32'(rd_out), 32'(0));
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'(0), 32'(0), 4'(0));
        step();

        // Fill every word so later reads have defined expectations.
        for (int i = 0; i < DEPTH; i++)
            access(1'b0, 1'b0, 1'b1, 32'(BASE + 4 * i), $urandom, 4'(i));

        // Store then load at the base address.
        access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 4'd1);
        access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd2);

        // Non-memory pass-through.
        nonmem(1'b1, 32'h55, 4'd3);

        // Out-of-range store must not alias word 0; load of it returns 0.
        access(1'b0, 1'b0, 1'b1, 32'(BASE + 4 * DEPTH), 32'hBADBAD00, 4'd4);
        access(1'b1, 1'b1, 1'b0, 32'(BASE + 4 * DEPTH), 32'h0, 4'd4);
        access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd6);
        access(1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 4'd6);

        // Reset in the second freeze cycle of a store aborts it.
        drive(1'b0, 1'b0, 1'b1, 32'd1028, 32'h1234, 4'd7);
        #2;
        check("abort_freeze1", 32'(freeze), 32'(1));
        step();
        rst = 1'b1;
        #2;
        check("abort_freeze_drop", 32'(freeze), 32'(0));
        check("abort_alu", alu_out, 32'(0));
        check("abort_wb", 32'(wb_out), 32'(0));
        step();
        rst = 1'b0;
        nonmem(1'b1, 32'hA5A5, 4'd9);
        access(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd8);

        // Read and write both high: write only.
        access(1'b1, 1'b1, 1'b1, 32'd1036, 32'h77, 4'd10);
        access(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd11);

        // Single-cycle instance: back-to-back store/load, both-high, out of range.
        access0(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
        access0(1'b1, 1'b0, 32'd1032, 32'h0);
        access0(1'b1, 1'b1, 32'd1036, 32'h77);
        access0(1'b1, 1'b0, 32'd1039, 32'h0);
        access0(1'b0, 1'b1, 32'(BASE + 4 * DEPTH), 32'h1111);
        access0(1'b1, 1'b0, 32'd1024, 32'h0);
        for (int i = 0; i < 20; i++) begin
            a = rand_addr();
            access0(1'b0, 1'b1, a, $urandom);
            access0(1'b1, 1'b0, a, 32'h0);
        end

        // Randomized traffic on the multi-cycle instance.
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 3));
            a  = rand_addr();
            case (op)
                0:       nonmem(1'($urandom), $urandom, 4'($urandom));
                1:       access(1'($urandom), 1'b1, 1'b0, a, $urandom, 4'($urandom));
                2:       access(1'($urandom), 1'b0, 1'b1, a, $urandom, 4'($urandom));
                default: access(1'($urandom), 1'b1, 1'b1, a, $urandom, 4'($urandom));
            endcase
        end

        // Read back every word once more.
        for (int i = 0; i < DEPTH; i++)
            access(1'b1, 1'b1, 1'b0, 32'(BASE + 4 * i), 32'h0, 4'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
